// File: rtl/csr_trap_seq_pkg.sv
// Shared constants and types for the trap/return sequencer.
//  - CSR addresses for the CSRs the sequencer writes
//  - mstatus/mie bit positions
//  - default mcause values
//  - FSM state encoding
package csr_trap_seq_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CSR_AW = 12;

    localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;
    localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
    localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;

    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;
    localparam int unsigned MIE_MTIE_BIT     = 7;
    localparam int unsigned MIE_MEIE_BIT     = 11;

    localparam logic [XLEN-1:0] DEF_CAUSE_ECALL  = 32'd11;
    localparam logic [XLEN-1:0] DEF_CAUSE_EBREAK = 32'd3;
    localparam logic [XLEN-1:0] DEF_CAUSE_TIMER  = 32'h8000_0007;
    localparam logic [XLEN-1:0] DEF_CAUSE_EXT    = 32'h8000_000B;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        W_MEPC    = 3'd1,
        W_MCAUSE  = 3'd2,
        W_MSTATUS = 3'd3,
        R_MSTATUS = 3'd4,
        JUMP_T    = 3'd5,
        JUMP_R    = 3'd6
    } trap_state_e;

endpackage

// File: rtl/trap_cause_pri.sv
// Event priority select: ecall > ebreak > mret > external irq > timer irq.
// Ports:
//  inst_valid      qualified valid (caller gates with its idle state)
//  ecall/ebreak/mret  synchronous events from exu
//  irq_ext_en/irq_timer_en  interrupts already masked by MIE and mie
//  exu_csr_we      exu owns the CSR port this cycle; interrupts wait
//  accept          an event is taken this cycle
//  is_mret         the taken event is mret
//  cause           mcause value for a taken trap (0 for mret / none)
module trap_cause_pri
    import csr_trap_seq_pkg::*;
#(
    parameter logic [XLEN-1:0] CAUSE_ECALL  = DEF_CAUSE_ECALL,
    parameter logic [XLEN-1:0] CAUSE_EBREAK = DEF_CAUSE_EBREAK,
    parameter logic [XLEN-1:0] CAUSE_TIMER  = DEF_CAUSE_TIMER,
    parameter logic [XLEN-1:0] CAUSE_EXT    = DEF_CAUSE_EXT
) (
    input  logic            inst_valid,
    input  logic            ecall,
    input  logic            ebreak,
    input  logic            mret,
    input  logic            irq_ext_en,
    input  logic            irq_timer_en,
    input  logic            exu_csr_we,
    output logic            accept,
    output logic            is_mret,
    output logic [XLEN-1:0] cause
);

    always_comb begin
        accept  = 1'b0;
        is_mret = 1'b0;
        cause   = '0;
        if (inst_valid) begin
            if (ecall) begin
                accept = 1'b1;
                cause  = CAUSE_ECALL;
            end else if (ebreak) begin
                accept = 1'b1;
                cause  = CAUSE_EBREAK;
            end else if (mret) begin
                accept  = 1'b1;
                is_mret = 1'b1;
            end else if (!exu_csr_we) begin
                // interrupts yield to an exu CSR write and retry next cycle
                if (irq_ext_en) begin
                    accept = 1'b1;
                    cause  = CAUSE_EXT;
                end else if (irq_timer_en) begin
                    accept = 1'b1;
                    cause  = CAUSE_TIMER;
                end
            end
        end
    end

endmodule

// File: rtl/csr_trap_seq.sv
// Trap/return sequencer driving the csr_reg clint write port.
// Traps write mepc, mcause, mstatus then redirect fetch to mtvec;
// mret restores mstatus then redirects to mepc. Stalls exu throughout.
// Ports:
//  clk, rst_n                 clock, async active-low reset
//  inst_valid_i, inst_addr_i  exu instruction valid and its PC
//  ecall_i, ebreak_i, mret_i  exu instruction decode
//  irq_timer_i, irq_ext_i     pending interrupt levels
//  exu_csr_we_i               exu CSR write this cycle
//  mtvec_i, mepc_i, mstatus_i, mie_i  csr_reg read values
//  csr_we_o, csr_waddr_o, csr_wdata_o  clint write port
//  stall_o                    pipeline hold
//  jump_o, jump_addr_o        one-cycle fetch redirect
module csr_trap_seq
    import csr_trap_seq_pkg::*;
#(
    parameter logic [XLEN-1:0] CAUSE_ECALL  = DEF_CAUSE_ECALL,
    parameter logic [XLEN-1:0] CAUSE_EBREAK = DEF_CAUSE_EBREAK,
    parameter logic [XLEN-1:0] CAUSE_TIMER  = DEF_CAUSE_TIMER,
    parameter logic [XLEN-1:0] CAUSE_EXT    = DEF_CAUSE_EXT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inst_valid_i,
    input  logic [XLEN-1:0] inst_addr_i,
    input  logic            ecall_i,
    input  logic            ebreak_i,
    input  logic            mret_i,
    input  logic            irq_timer_i,
    input  logic            irq_ext_i,
    input  logic            exu_csr_we_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    input  logic [XLEN-1:0] mstatus_i,
    input  logic [XLEN-1:0] mie_i,
    output logic            csr_we_o,
    output logic [XLEN-1:0] csr_waddr_o,
    output logic [XLEN-1:0] csr_wdata_o,
    output logic            stall_o,
    output logic            jump_o,
    output logic [XLEN-1:0] jump_addr_o
);

    trap_state_e     state;
    logic [XLEN-1:0] cause_q;
    logic [XLEN-1:0] epc_q;

    logic            idle;
    logic            accept;
    logic            is_mret;
    logic [XLEN-1:0] cause;
    logic            irq_ext_en;
    logic            irq_timer_en;
    logic            unused_bits;

    assign idle         = (state == IDLE);
    assign irq_ext_en   = irq_ext_i   & mstatus_i[MSTATUS_MIE_BIT] & mie_i[MIE_MEIE_BIT];
    assign irq_timer_en = irq_timer_i & mstatus_i[MSTATUS_MIE_BIT] & mie_i[MIE_MTIE_BIT];
    assign unused_bits  = ^{mtvec_i[1:0], mie_i};

    // Events are only considered while idle; everything is ignored mid-sequence.
    trap_cause_pri #(
        .CAUSE_ECALL  (CAUSE_ECALL),
        .CAUSE_EBREAK (CAUSE_EBREAK),
        .CAUSE_TIMER  (CAUSE_TIMER),
        .CAUSE_EXT    (CAUSE_EXT)
    ) u_pri (
        .inst_valid   (inst_valid_i & idle),
        .ecall        (ecall_i),
        .ebreak       (ebreak_i),
        .mret         (mret_i),
        .irq_ext_en   (irq_ext_en),
        .irq_timer_en (irq_timer_en),
        .exu_csr_we   (exu_csr_we_i),
        .accept       (accept),
        .is_mret      (is_mret),
        .cause        (cause)
    );

    // State register plus latched cause/epc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cause_q <= '0;
            epc_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cause_q <= cause;
                        epc_q   <= inst_addr_i;
                        state   <= is_mret ? R_MSTATUS : W_MEPC;
                    end
                end
                W_MEPC:    state <= W_MCAUSE;
                W_MCAUSE:  state <= W_MSTATUS;
                W_MSTATUS: state <= JUMP_T;
                R_MSTATUS: state <= JUMP_R;
                JUMP_T:    state <= IDLE;
                JUMP_R:    state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

    // Output decode; mstatus is rebuilt from the live csr_reg value.
    always_comb begin
        logic [XLEN-1:0] ms;
        csr_we_o    = 1'b0;
        csr_waddr_o = '0;
        csr_wdata_o = '0;
        jump_o      = 1'b0;
        jump_addr_o = '0;
        stall_o     = !idle || accept;
        ms          = mstatus_i;
        case (state)
            W_MEPC: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = XLEN'(CSR_MEPC);
                csr_wdata_o = epc_q;
            end
            W_MCAUSE: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = XLEN'(CSR_MCAUSE);
                csr_wdata_o = cause_q;
            end
            W_MSTATUS: begin
                ms[MSTATUS_MPIE_BIT] = mstatus_i[MSTATUS_MIE_BIT];
                ms[MSTATUS_MIE_BIT]  = 1'b0;
                csr_we_o    = 1'b1;
                csr_waddr_o = XLEN'(CSR_MSTATUS);
                csr_wdata_o = ms;
            end
            R_MSTATUS: begin
                ms[MSTATUS_MIE_BIT]  = mstatus_i[MSTATUS_MPIE_BIT];
                ms[MSTATUS_MPIE_BIT] = 1'b1;
                csr_we_o    = 1'b1;
                csr_waddr_o = XLEN'(CSR_MSTATUS);
                csr_wdata_o = ms;
            end
            JUMP_T: begin
                jump_o      = 1'b1;
                jump_addr_o = {mtvec_i[XLEN-1:2], 2'b00};
            end
            JUMP_R: begin
                jump_o      = 1'b1;
                jump_addr_o = mepc_i;
            end
            default: ;
        endcase
    end

endmodule
